// File: rtl/spi_master_param.sv
// Parameterised SPI master: IDLE/SETUP/SHIFT/HOLD sequencer, CPOL/CPHA modes, per-slave chip selects.
// Optional build macro SPI_MASTER_PARAM_LSB_FIRST_EN adds an LSB_FIRST input latched at START.
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int CS_N   = 1,
  parameter int DIV_W  = 8,
  localparam int CSEL_W = (CS_N > 1) ? $clog2(CS_N) : 1
) (
  input  logic              CTRL_CLK,
  input  logic              NRST,
  input  logic              START,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic [CSEL_W-1:0] CS_SEL,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic [DIV_W-1:0]  CLK_DIV,
`ifdef SPI_MASTER_PARAM_LSB_FIRST_EN
  input  logic              LSB_FIRST,
`endif
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RX_DATA,
  input  logic              MISO,
  output logic [CS_N-1:0]   CS_N_OUT,
  output logic              SCLK,
  output logic              MOSI
);
  localparam int EDGE_W = $clog2(2 * DATA_W) + 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t              r_state, w_state_nxt;
  logic [DIV_W-1:0]    r_cnt, r_div;
  logic [EDGE_W-1:0]   r_edge;
  logic [DATA_W-1:0]   r_tx, r_rx, r_rx_data;
  logic [CSEL_W-1:0]   r_csel;
  logic                r_cpol, r_cpha, r_sclk, r_mosi, r_done;
  logic                w_hdone, w_lsb, w_lsb_in;
  logic [DATA_W-1:0]   w_rx_next;

`ifdef SPI_MASTER_PARAM_LSB_FIRST_EN
  logic r_lsb;
  always_ff @(posedge CTRL_CLK) begin
    if (!NRST)                            r_lsb <= 1'b0;
    else if (r_state == IDLE && START)    r_lsb <= LSB_FIRST;
  end
  assign w_lsb    = r_lsb;
  assign w_lsb_in = LSB_FIRST;
`else
  assign w_lsb    = 1'b0;
  assign w_lsb_in = 1'b0;
`endif

  assign w_hdone   = (r_cnt == r_div);
  assign w_rx_next = w_lsb ? {MISO, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], MISO};

  always_ff @(posedge CTRL_CLK) begin
    if (!NRST) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (START) w_state_nxt = SETUP;
      SETUP: if (w_hdone) w_state_nxt = SHIFT;
      SHIFT: if (w_hdone && r_edge == LAST_EDGE) w_state_nxt = HOLD;
      HOLD:  if (w_hdone) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CTRL_CLK) begin
    if (!NRST) begin
      r_cnt <= '0; r_div <= '0; r_edge <= '0;
      r_tx <= '0; r_rx <= '0; r_rx_data <= '0; r_csel <= '0;
      r_cpol <= 1'b0; r_cpha <= 1'b0; r_sclk <= 1'b0; r_mosi <= 1'b0; r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        r_cnt  <= '0;
        r_edge <= '0;
        r_sclk <= r_cpol;
        if (START) begin
          r_div  <= CLK_DIV;
          r_csel <= CS_SEL;
          r_cpol <= CPOL;
          r_cpha <= CPHA;
          r_sclk <= CPOL;
          r_rx   <= '0;
          // CPHA=0 needs the first bit on MOSI before the first (sampling) edge
          if (!CPHA) begin
            r_mosi <= w_lsb_in ? TX_DATA[0] : TX_DATA[DATA_W-1];
            r_tx   <= w_lsb_in ? (TX_DATA >> 1) : (TX_DATA << 1);
          end else begin
            r_mosi <= 1'b0;
            r_tx   <= TX_DATA;
          end
        end
      end else begin
        r_cnt <= w_hdone ? '0 : r_cnt + DIV_W'(1);
        if (r_state == SHIFT && w_hdone) begin
          r_sclk <= ~r_sclk;
          r_edge <= r_edge + EDGE_W'(1);
          // even r_edge = leading edge (1st, 3rd, ...)
          if ((!r_edge[0] && !r_cpha) || (r_edge[0] && r_cpha)) begin
            r_rx <= w_rx_next;
          end else if (r_cpha || r_edge != LAST_EDGE) begin
            r_mosi <= w_lsb ? r_tx[0] : r_tx[DATA_W-1];
            r_tx   <= w_lsb ? (r_tx >> 1) : (r_tx << 1);
          end
        end
        if (r_state == HOLD && w_hdone) begin
          r_rx_data <= r_rx;
          r_done    <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    CS_N_OUT = '1;
    for (int i = 0; i < CS_N; i++)
      if (r_state != IDLE && r_csel == CSEL_W'(i)) CS_N_OUT[i] = 1'b0;
  end

  assign BUSY    = (r_state != IDLE);
  assign DONE    = r_done;
  assign RX_DATA = r_rx_data;
  assign SCLK    = r_sclk;
  assign MOSI    = (r_state == IDLE) ? 1'b0 : r_mosi;
endmodule
